fifo_push_arbiter: RTL

- Round-robin push arbiter that shares one `circular_pointer_fifo` write port between `NREQ` producers.
- Sits between the producers and the FIFO's `push`/`data_in`/`full` pins. The consumer drives `pop` directly and is outside this block.
- Guarantees at most one push per cycle, never pushes while the FIFO is full, and bounds wait time for every requester that holds its request.

---
 rtl/fifo_push_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
// Round-robin arbiter that lets NREQ producers share the single write port of
// a FIFO. Grants are combinational and gated by fifo_full; at most one push
// per cycle.
//
// Optional feature: define ARB_BURST_EN to compile in the IDLE/HOLD burst
// state machine. Then one grant covers up to BURST_LEN consecutive pushes by
// the same owner. Without the macro, every push rotates the pointer and busy
// is tied to 0.
//
// Handshake: requester i holds req[i] and its data stable until it sees
// gnt[i]=1. Its data is consumed on any clk edge where gnt[i]=1. gnt is
// one-hot or zero. fifo_push equals |gnt.
module fifo_push_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 2,
    parameter int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic                    fifo_full,
    output logic [NREQ-1:0]         gnt,
    output logic                    fifo_push,
    output logic [WIDTH-1:0]        fifo_data_in,
    output logic [IW-1:0]           owner,
    output logic                    busy
);

    // Elaboration-time sanity check of the configuration.
    if (NREQ < 2 || NREQ > 16 || BURST_LEN < 1 || DEPTH < 1) begin : g_param_check
        $error("fifo_push_arbiter: illegal parameter set");
    end

    // Increment modulo NREQ. This also works when NREQ is not a power of two.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (idx == IW'(NREQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] scan_start;
    logic [IW-1:0] scan_idx;
    logic          scan_hit;
    logic [IW-1:0] win_idx;
    logic          grant_any;

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [CW-1:0] burst_cnt_inc;
    logic          busy_q, busy_d;
    logic          in_hold;
    logic          hold_cont;

    assign in_hold       = (state_q == ST_HOLD);
    assign hold_cont     = in_hold && req[owner_q];
    assign burst_cnt_inc = burst_cnt_q + 1'b1;
    // When the owner drops its request, the hold ends and the scan resumes after it.
    assign scan_start    = in_hold ? next_idx(owner_q) : rr_ptr_q;
`else
    assign scan_start    = rr_ptr_q;
`endif

    // Round-robin scan: first set req bit from scan_start upward, with wrap.
    always_comb begin
        int j;
        logic [IW-1:0] idx;
        scan_hit = 1'b0;
        scan_idx = '0;
        j        = 0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(scan_start) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            idx = IW'(j);
            if (!scan_hit && req[idx]) begin
                scan_hit = 1'b1;
                scan_idx = idx;
            end
        end
    end

    // Winner selection: nothing during reset or while the FIFO is full.
    always_comb begin
        grant_any = 1'b0;
        win_idx   = '0;
        if (!rst && !fifo_full) begin
`ifdef ARB_BURST_EN
            if (hold_cont) begin
                grant_any = 1'b1;
                win_idx   = owner_q;
            end else if (scan_hit) begin
                grant_any = 1'b1;
                win_idx   = scan_idx;
            end
`else
            if (scan_hit) begin
                grant_any = 1'b1;
                win_idx   = scan_idx;
            end
`endif
        end
    end

    // One-hot grant and data mux for the FIFO write port.
    always_comb begin
        gnt          = '0;
        fifo_data_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && (win_idx == IW'(i))) begin
                gnt[i]       = 1'b1;
                fifo_data_in = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_push = grant_any;
    assign owner     = owner_q;

`ifdef ARB_BURST_EN
    // Next-state logic for the pointer, owner and burst hold.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        busy_d      = busy_q;
        if (grant_any) begin
            if (hold_cont) begin
                // The owner continues its burst. The burst closes when it reaches BURST_LEN.
                if (burst_cnt_inc == CW'(BURST_LEN)) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    burst_cnt_d = '0;
                    rr_ptr_d    = next_idx(owner_q);
                end else begin
                    burst_cnt_d = burst_cnt_inc;
                end
            end else if (BURST_LEN > 1) begin
                // A new winner opens a hold. rr_ptr stays put until the burst closes.
                owner_d     = win_idx;
                burst_cnt_d = CW'(1);
                state_d     = ST_HOLD;
                busy_d      = 1'b1;
            end else begin
                rr_ptr_d = next_idx(win_idx);
                owner_d  = win_idx;
            end
        end else if (in_hold && !fifo_full && !rst) begin
            // The owner dropped and nobody else is requesting: release the hold.
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            burst_cnt_d = '0;
            rr_ptr_d    = next_idx(owner_q);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    // Next-state logic: every push rotates the pointer past the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (grant_any) begin
            rr_ptr_d = next_idx(win_idx);
            owner_d  = win_idx;
        end
    end

    // Pointer and owner registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    assign busy = 1'b0;
`endif

endmodule
